// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states and byte-lane selectors.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and DataMemory port bundle for the load/store unit.
// slave: the unit itself; master: the execute/write-back side plus DataMemory.
interface load_store_unit_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();

    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic          ReqByte;
    logic          ReqSigned;
    logic [AW-1:0] ReqAddr;
    logic [DW-1:0] ReqData;
    logic          RespValid;
    logic [DW-1:0] RespData;
    logic          RespErr;
    logic [AW-1:0] Adresa;
    logic [DW-1:0] WriteData;
    logic          MemWrite;
    logic          MemRead;
    logic [DW-1:0] ReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqByte, ReqSigned, ReqAddr, ReqData, ReadData,
        output ReqReady, RespValid, RespData, RespErr, Adresa, WriteData, MemWrite, MemRead
    );

    modport master (
        output ReqValid, ReqWrite, ReqByte, ReqSigned, ReqAddr, ReqData, ReadData,
        input  ReqReady, RespValid, RespData, RespErr, Adresa, WriteData, MemWrite, MemRead
    );

endinterface

// File: rtl/byte_lane_merge.sv
// Byte-lane helper: replaces one lane of a memory word with a store byte, and
// extracts one lane of a memory word as a sign- or zero-extended load value.
module byte_lane_merge
    import lsu_pkg::*;
(
    input  logic [15:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic        lane_i,
    input  logic        signed_i,
    output logic [15:0] merged_o,
    output logic [15:0] load_o
);

    logic [7:0] sel_byte;

    // Lane selection for both the store merge and the load extension.
    always_comb begin
        merged_o = word_i;
        sel_byte = word_i[7:0];
        if (lane_i == LANE_HI) begin
            merged_o[15:8] = byte_i;
            sel_byte       = word_i[15:8];
        end else begin
            merged_o[7:0]  = byte_i;
        end
        load_o = {{8{signed_i & sel_byte[7]}}, sel_byte};
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences execute-stage requests onto DataMemory, converting
// byte addresses to word addresses, doing byte stores as read-modify-write and
// byte loads with sign/zero extension, and pulsing one response per request.
// Optional build macro LSU_MISALIGN_TRAP_EN: word accesses with ReqAddr[0]=1
// skip the memory cycle and respond immediately with RespErr=1.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    load_store_unit_if.slave bus
);

    lsu_state_t    state_q;
    logic          ready_q;
    logic          write_q;
    logic          byte_q;
    logic          signed_q;
    logic          lane_q;
    logic [7:0]    store_byte_q;
    logic [AW-1:0] adresa_q;
    logic [DW-1:0] wdata_q;
    logic          mem_write_q;
    logic          mem_read_q;
    logic          resp_valid_q;
    logic [DW-1:0] resp_data_q;
    logic          resp_err_q;

    logic [15:0]   merged_d;
    logic [15:0]   load_ext_d;
    logic          misalign_d;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_d = !bus.ReqByte && bus.ReqAddr[0];
`else
    assign misalign_d = 1'b0;
`endif

    // Lanes are taken from ReadData directly on the edge that ends RD.
    byte_lane_merge u_merge (
        .word_i   (bus.ReadData),
        .byte_i   (store_byte_q),
        .lane_i   (lane_q),
        .signed_i (signed_q),
        .merged_o (merged_d),
        .load_o   (load_ext_d)
    );

    // Request sequencing FSM with all bus outputs registered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            signed_q     <= 1'b0;
            lane_q       <= LANE_LO;
            store_byte_q <= '0;
            adresa_q     <= '0;
            wdata_q      <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ReqValid && ready_q) begin
                        ready_q      <= 1'b0;
                        write_q      <= bus.ReqWrite;
                        byte_q       <= bus.ReqByte;
                        signed_q     <= bus.ReqSigned;
                        lane_q       <= bus.ReqAddr[0];
                        store_byte_q <= bus.ReqData[7:0];
                        adresa_q     <= {1'b0, bus.ReqAddr[AW-1:1]};
                        if (misalign_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else if (bus.ReqWrite && !bus.ReqByte) begin
                            state_q     <= WR;
                            mem_write_q <= 1'b1;
                            wdata_q     <= bus.ReqData;
                        end else begin
                            state_q    <= RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    mem_read_q <= 1'b0;
                    if (write_q) begin
                        state_q     <= WR;
                        mem_write_q <= 1'b1;
                        wdata_q     <= merged_d;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= byte_q ? load_ext_d : bus.ReadData;
                    end
                end
                WR: begin
                    mem_write_q  <= 1'b0;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= '0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReqReady  = ready_q;
    assign bus.RespValid = resp_valid_q;
    assign bus.RespData  = resp_data_q;
    assign bus.RespErr   = resp_err_q;
    assign bus.Adresa    = adresa_q;
    assign bus.WriteData = wdata_q;
    assign bus.MemWrite  = mem_write_q;
    assign bus.MemRead   = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a DataMemory model and a response scoreboard.
module tb_load_store_unit;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          due;
        logic [15:0] adr;
        logic [15:0] wdata;
        int          nrd;
        int          nwr;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          errors;
    int          checks;
    exp_t        sb[$];
    int          cur_rd;
    int          cur_wr;
    int          tot_wr;

    logic [15:0] mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;

    load_store_unit_if #(.AW(16), .DW(16)) bus ();

    load_store_unit #(.AW(16), .DW(16)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.ReadData = mem[bus.Adresa];

    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.Adresa] <= bus.WriteData;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [15:0] d, input logic er, input logic [15:0] a,
                                input logic [15:0] w, input int nr, input int nw);
        exp_t e;
        e.data = d; e.err = er; e.due = 0; e.adr = a; e.wdata = w; e.nrd = nr; e.nwr = nw;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.MemRead || bus.MemWrite || bus.RespValid) begin
                chk("ready_low_busy", {31'd0, bus.ReqReady}, 32'd0);
                chk("rd_wr_exclusive", {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
            end
            if (bus.MemRead || bus.MemWrite) begin
                chk("memcycle_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    chk("adresa", {16'd0, bus.Adresa}, {16'd0, sb[0].adr});
                    if (bus.MemWrite) chk("writedata", {16'd0, bus.WriteData}, {16'd0, sb[0].wdata});
                end
                if (bus.MemRead) cur_rd++;
                if (bus.MemWrite) begin cur_wr++; tot_wr++; end
            end
            if (bus.RespValid) begin
                chk("resp_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("resp_data", {16'd0, bus.RespData}, {16'd0, e.data});
                    chk("resp_err", {31'd0, bus.RespErr}, {31'd0, e.err});
                    chk("resp_latency", cyc + 1, e.due);
                    chk("memread_cycles", cur_rd, e.nrd);
                    chk("memwrite_cycles", cur_wr, e.nwr);
                end
                cur_rd = 0;
                cur_wr = 0;
            end
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
        @(negedge clk);
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic do_req(input logic wr, input logic by, input logic sg,
                          input logic [15:0] addr, input logic [15:0] data,
                          input exp_t e_in, input int lat, input logic hold, output int acc);
        exp_t e;
        logic got;
        e = e_in;
        got = 1'b0;
        acc = -1;
        bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.ReqByte = by; bus.ReqSigned = sg;
        bus.ReqAddr = addr; bus.ReqData = data;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus.ReqReady) begin
                @(posedge clk);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            #1;
            acc = cyc;
            e.due = acc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        if (!hold) bus.ReqValid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("resp_timeout", {31'd0, sb.size() == 0}, 32'd1);
        sb.delete();
        @(negedge clk);
    endtask

    int acc1, acc2, wr_snap;

    initial begin
        errors = 0; checks = 0; cur_rd = 0; cur_wr = 0; tot_wr = 0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        rst = 1'b1;
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqByte = 1'b0; bus.ReqSigned = 1'b0;
        bus.ReqAddr = '0; bus.ReqData = '0;
        fork monitor_loop(); join_none
        repeat (3) @(negedge clk);
        chk("rst_ReqReady", {31'd0, bus.ReqReady}, 32'd1);
        chk("rst_RespValid", {31'd0, bus.RespValid}, 32'd0);
        chk("rst_RespData", {16'd0, bus.RespData}, 32'd0);
        chk("rst_RespErr", {31'd0, bus.RespErr}, 32'd0);
        chk("rst_Adresa", {16'd0, bus.Adresa}, 32'd0);
        chk("rst_WriteData", {16'd0, bus.WriteData}, 32'd0);
        chk("rst_MemWrite", {31'd0, bus.MemWrite}, 32'd0);
        chk("rst_MemRead", {31'd0, bus.MemRead}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store then load
        do_req(1, 0, 0, 16'h0018, 16'hBEEF, mk(16'h0000, 0, 16'h000C, 16'hBEEF, 0, 1), 2, 0, acc1);
        wait_done();
        do_req(0, 0, 0, 16'h0018, 16'h0000, mk(16'hBEEF, 0, 16'h000C, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();

        // Byte store read-modify-write, high lane
        preload(16'h000C, 16'h1234);
        do_req(1, 1, 0, 16'h0019, 16'h55AB, mk(16'h0000, 0, 16'h000C, 16'hAB34, 1, 1), 3, 0, acc1);
        wait_done();
        chk("mem12_after_bstore", {16'd0, mem[16'h000C]}, 32'h0000AB34);
        do_req(0, 0, 0, 16'h0018, 16'h0000, mk(16'hAB34, 0, 16'h000C, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();

        // Byte load extension
        preload(16'h0005, 16'h80F0);
        do_req(0, 1, 1, 16'h000B, 16'h0000, mk(16'hFF80, 0, 16'h0005, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
        do_req(0, 1, 0, 16'h000A, 16'h0000, mk(16'h00F0, 0, 16'h0005, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
        do_req(0, 1, 1, 16'h000A, 16'h0000, mk(16'hFFF0, 0, 16'h0005, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
        do_req(0, 1, 0, 16'h000B, 16'h0000, mk(16'h0080, 0, 16'h0005, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();

        // Byte store low lane
        do_req(1, 1, 0, 16'h000A, 16'hFF5A, mk(16'h0000, 0, 16'h0005, 16'h805A, 1, 1), 3, 0, acc1);
        wait_done();

        // Address wrap at top of byte space
        preload(16'h7FFF, 16'hC3A5);
        do_req(0, 1, 0, 16'hFFFF, 16'h0000, mk(16'h00C3, 0, 16'h7FFF, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
        do_req(1, 1, 0, 16'hFFFF, 16'h0011, mk(16'h0000, 0, 16'h7FFF, 16'h11A5, 1, 1), 3, 0, acc1);
        wait_done();
        chk("mem7fff_after_wrap", {16'd0, mem[16'h7FFF]}, 32'h000011A5);
        chk("mem0_untouched", {16'd0, mem[16'h0000]}, 32'h00000000);

        // Back-to-back with ReqValid held high
        do_req(1, 0, 0, 16'h0020, 16'h1111, mk(16'h0000, 0, 16'h0010, 16'h1111, 0, 1), 2, 1, acc1);
        do_req(0, 0, 0, 16'h0020, 16'h0000, mk(16'h1111, 0, 16'h0010, 16'h0000, 1, 0), 2, 0, acc2);
        chk("b2b_accept_cycle", acc2, acc1 + 3);
        wait_done();

        // Reset during RD of a byte store
        preload(16'h000C, 16'h1234);
        wr_snap = tot_wr;
        do_req(1, 1, 0, 16'h0019, 16'h00AB, mk(16'h0000, 0, 16'h000C, 16'hAB34, 1, 1), 3, 0, acc1);
        chk("rst_mid_in_rd", {31'd0, bus.MemRead}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_memread", {31'd0, bus.MemRead}, 32'd0);
        sb.delete();
        cur_rd = 0;
        cur_wr = 0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, bus.ReqReady}, 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_mid_no_write", tot_wr, wr_snap);
        chk("rst_mid_mem12", {16'd0, mem[16'h000C]}, 32'h00001234);
        do_req(0, 0, 0, 16'h0018, 16'h0000, mk(16'h1234, 0, 16'h000C, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();

        // Misaligned word accesses
        preload(16'h0009, 16'h2468);
        preload(16'h000A, 16'h0A0A);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(0, 0, 0, 16'h0013, 16'h0000, mk(16'h0000, 1, 16'h0009, 16'h0000, 0, 0), 1, 0, acc1);
        wait_done();
        do_req(1, 0, 0, 16'h0015, 16'h7777, mk(16'h0000, 1, 16'h000A, 16'h0000, 0, 0), 1, 0, acc1);
        wait_done();
        do_req(0, 0, 0, 16'h0014, 16'h0000, mk(16'h0A0A, 0, 16'h000A, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
`else
        do_req(0, 0, 0, 16'h0013, 16'h0000, mk(16'h2468, 0, 16'h0009, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
        do_req(1, 0, 0, 16'h0015, 16'h7777, mk(16'h0000, 0, 16'h000A, 16'h7777, 0, 1), 2, 0, acc1);
        wait_done();
        do_req(0, 0, 0, 16'h0014, 16'h0000, mk(16'h7777, 0, 16'h000A, 16'h0000, 1, 0), 2, 0, acc1);
        wait_done();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
